// File: rtl/cdc_wr_arbiter.sv
// cdc_wr_arbiter
// Round-robin arbiter that shares the write port of a clock-domain-crossing
// FIFO among N requesters in the write clock domain. One word is staged in
// an output register and tagged {last, id, payload} so the read side can
// demultiplex it. A requester keeps the grant from its first word until the
// word marked last, which keeps multi-word bursts contiguous.
//
// Ports:
//   clk         write-domain clock (same as the FIFO write clock)
//   rst_n       synchronous active-low reset
//   req_valid   per-requester word present
//   req_data    per-requester payload, requester i in [i*W +: W]
//   req_last    per-requester end-of-burst marker
//   req_ack     one-hot accept pulse, combinational in the load cycle
//   fifo_wdata  staged word {last, id, payload}
//   fifo_wput   FIFO write strobe
//   fifo_wrdy   FIFO not full
//   locked      a burst is in progress
//   owner       requester holding the burst lock
module cdc_wr_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ack,
  output logic [W+IDW:0]   fifo_wdata,
  output logic             fifo_wput,
  input  logic             fifo_wrdy,
  output logic             locked,
  output logic [IDW-1:0]   owner
);

  logic           out_valid;
  logic [IDW-1:0] rr_ptr;

  logic           load_en;
  logic           load;
  logic           found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] next_ptr;
  logic [W-1:0]   grant_data;
  logic           grant_last;

  // Reset gates the strobe so a staged word is discarded rather than
  // written during the reset cycle.
  assign fifo_wput = rst_n & out_valid & fifo_wrdy;

  // The register can take a new word when it is empty or is being drained
  // this very cycle, which gives back-to-back transfers.
  assign load_en = !out_valid | fifo_wput;

  assign load = rst_n & load_en & found;

  // While locked only the owner may be granted, even if it has dropped
  // valid; otherwise search upward from rr_ptr, wrapping modulo N.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    found    = 1'b0;
    grant_id = '0;
    sum      = '0;
    idx      = '0;
    if (locked) begin
      found    = req_valid[owner];
      grant_id = owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        sum = {1'b0, rr_ptr} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(N)) begin
          sum = sum - (IDW+1)'(N);
        end
        idx = sum[IDW-1:0];
        if (!found && req_valid[idx]) begin
          found    = 1'b1;
          grant_id = idx;
        end
      end
    end
  end

  // Mux out the granted requester's payload and last flag, and form the
  // one-hot ack.
  always_comb begin
    grant_data = '0;
    grant_last = 1'b0;
    req_ack    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id == IDW'(i)) begin
        grant_data = req_data[i*W +: W];
        grant_last = req_last[i];
        req_ack[i] = load;
      end
    end
  end

  assign next_ptr = (grant_id == IDW'(N-1)) ? '0 : grant_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      rr_ptr     <= '0;
      locked     <= 1'b0;
      owner      <= '0;
      fifo_wdata <= '0;
    end else begin
      if (load) begin
        fifo_wdata <= {grant_last, grant_id, grant_data};
        out_valid  <= 1'b1;
        if (grant_last) begin
          locked <= 1'b0;
          rr_ptr <= next_ptr;
        end else begin
          locked <= 1'b1;
          owner  <= grant_id;
        end
      end else if (fifo_wput) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdc_wr_arbiter.sv
// tb_cdc_wr_arbiter
// Self-checking bench for cdc_wr_arbiter. Requesters are modelled as word
// queues; a reference model of the arbiter predicts acks, strobes and the
// lock state each cycle, and expected FIFO words go into a scoreboard when
// granted and are compared when the FIFO put happens. The observed grant
// order of each scenario is also compared against a fixed expected order.
module tb_cdc_wr_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;
  localparam int DW  = W + IDW + 1;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [DW-1:0]  fifo_wdata;
  logic           fifo_wput;
  logic           fifo_wrdy;
  logic           locked;
  logic [IDW-1:0] owner;

  cdc_wr_arbiter #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ack    (req_ack),
    .fifo_wdata (fifo_wdata),
    .fifo_wput  (fifo_wput),
    .fifo_wrdy  (fifo_wrdy),
    .locked     (locked),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-requester pending words, each {last, payload}.
  logic [W:0]    rq [N][$];
  logic [N-1:0]  hold;
  logic [DW-1:0] sb [$];
  int            ack_log [$];
  int            exp_log [$];

  // Reference model state.
  logic           m_ov;
  logic           m_locked;
  logic [IDW-1:0] m_owner;
  logic [IDW-1:0] m_rr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check the model's
  // predictions mid-cycle, then advance the model at the rising edge.
  task automatic applyStimulus(input logic wrdy, input logic rst);
    logic          m_wput;
    logic          m_load_en;
    logic          m_found;
    logic          m_last;
    int            m_g;
    logic [DW-1:0] expw;
    @(negedge clk);
    rst_n     = rst;
    fifo_wrdy = wrdy;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !hold[i]) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = rq[i][0][W];
        req_data[i*W +: W] = rq[i][0][W-1:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*W +: W] = '0;
      end
    end
    #1;
    m_wput    = rst & m_ov & wrdy;
    m_load_en = !m_ov | m_wput;
    m_found   = 1'b0;
    m_g       = 0;
    m_last    = 1'b0;
    if (rst && m_load_en) begin
      if (m_locked) begin
        if (req_valid[m_owner]) begin
          m_found = 1'b1;
          m_g     = int'(m_owner);
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (int'(m_rr) + k) % N;
          if (!m_found && req_valid[idx]) begin
            m_found = 1'b1;
            m_g     = idx;
          end
        end
      end
    end
    if (m_found) m_last = req_last[m_g];
    checkOutput("ack", 32'(req_ack), m_found ? (32'd1 << m_g) : 32'd0);
    checkOutput("wput", 32'(fifo_wput), 32'(m_wput));
    checkOutput("locked", 32'(locked), 32'(m_locked));
    checkOutput("owner", 32'(owner), 32'(m_owner));
    if (m_ov && sb.size() > 0) begin
      if (m_wput) begin
        expw = sb.pop_front();
        checkOutput("wdata_put", 32'(fifo_wdata), 32'(expw));
      end else begin
        checkOutput("wdata_hold", 32'(fifo_wdata), 32'(sb[0]));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) ack_log.push_back(i);
    end
    if (m_found) sb.push_back({m_last, IDW'(m_g), req_data[m_g*W +: W]});
    @(posedge clk);
    if (!rst) begin
      m_ov     = 1'b0;
      m_locked = 1'b0;
      m_owner  = '0;
      m_rr     = '0;
      sb.delete();
    end else if (m_found) begin
      m_ov = 1'b1;
      if (m_last) begin
        m_locked = 1'b0;
        m_rr     = IDW'((m_g + 1) % N);
      end else begin
        m_locked = 1'b1;
        m_owner  = IDW'(m_g);
      end
      void'(rq[m_g].pop_front());
    end else if (m_wput) begin
      m_ov = 1'b0;
    end
  endtask

  function automatic bit busy();
    bit b;
    b = m_ov;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic runUntilIdle(input int max_cycles);
    int n;
    n = 0;
    while (busy() && n < max_cycles) begin
      applyStimulus(1'b1, 1'b1);
      n++;
    end
    checkOutput("idle_timeout", 32'(busy()), 32'd0);
  endtask

  task automatic checkOrder(input string tag);
    checkOutput({tag, "_len"}, 32'(ack_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < ack_log.size()) begin
        checkOutput($sformatf("%s_grant%0d", tag, i), 32'(ack_log[i]), 32'(exp_log[i]));
      end
    end
  endtask

  task automatic startTest();
    hold = '0;
    applyStimulus(1'b1, 1'b0);
    ack_log.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    fifo_wrdy = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    hold      = '0;
    m_ov      = 1'b0;
    m_locked  = 1'b0;
    m_owner   = '0;
    m_rr      = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ack", 32'(req_ack), 32'd0);
    checkOutput("rst_wput", 32'(fifo_wput), 32'd0);
    checkOutput("rst_wdata", 32'(fifo_wdata), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);

    $display("[TB] single requester");
    startTest();
    rq[2].push_back({1'b1, 8'h5A});
    runUntilIdle(10);
    exp_log = '{2};
    checkOrder("single");

    $display("[TB] round robin");
    startTest();
    rq[0].push_back({1'b1, 8'h10});
    rq[0].push_back({1'b1, 8'h14});
    rq[1].push_back({1'b1, 8'h11});
    rq[2].push_back({1'b1, 8'h12});
    rq[3].push_back({1'b1, 8'h13});
    runUntilIdle(20);
    exp_log = '{0, 1, 2, 3, 0};
    checkOrder("rr");

    $display("[TB] burst lock");
    startTest();
    rq[1].push_back({1'b0, 8'hB1});
    rq[1].push_back({1'b0, 8'hB2});
    rq[1].push_back({1'b1, 8'hB3});
    applyStimulus(1'b1, 1'b1);
    rq[0].push_back({1'b1, 8'hA0});
    rq[3].push_back({1'b1, 8'hA3});
    runUntilIdle(20);
    exp_log = '{1, 1, 1, 3, 0};
    checkOrder("burst");

    $display("[TB] backpressure");
    startTest();
    rq[1].push_back({1'b1, 8'h11});
    applyStimulus(1'b0, 1'b1);
    rq[0].push_back({1'b1, 8'h33});
    repeat (10) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    runUntilIdle(10);
    exp_log = '{1, 0};
    checkOrder("bp");

    $display("[TB] owner drop");
    startTest();
    rq[2].push_back({1'b0, 8'h21});
    rq[2].push_back({1'b0, 8'h22});
    rq[2].push_back({1'b1, 8'h23});
    applyStimulus(1'b1, 1'b1);
    hold[2] = 1'b1;
    rq[0].push_back({1'b1, 8'h07});
    repeat (5) applyStimulus(1'b1, 1'b1);
    hold[2] = 1'b0;
    runUntilIdle(20);
    exp_log = '{2, 2, 2, 0};
    checkOrder("drop");

    $display("[TB] reset mid-burst");
    startTest();
    rq[2].push_back({1'b0, 8'hC1});
    rq[2].push_back({1'b0, 8'hC2});
    rq[2].push_back({1'b1, 8'hC3});
    applyStimulus(1'b0, 1'b1);
    rq[1].push_back({1'b1, 8'h44});
    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("midrst_wdata", 32'(fifo_wdata), 32'd0);
    checkOutput("midrst_locked", 32'(locked), 32'd0);
    checkOutput("midrst_owner", 32'(owner), 32'd0);
    checkOutput("midrst_wput", 32'(fifo_wput), 32'd0);
    ack_log.delete();
    runUntilIdle(20);
    exp_log = '{1, 2, 2};
    checkOrder("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_wr_arbiter.md
# cdc_wr_arbiter

Round-robin arbiter that shares the write port of one clock-domain-crossing sync FIFO (`wdata`/`wput`/`wrdy`) among N requesters in the write clock domain. It holds one staged word in an output register and tags it with the source ID and an end-of-burst flag, so the read domain can demultiplex. It supports multi-word bursts: a requester keeps the grant from its first word until the word marked `last`. It sits directly in front of the FIFO's write interface and is clocked by the FIFO's write clock.

## Interface
Parameters:
- `N`, 4 — number of requesters; legal range 2..16.
- `W`, 8 — payload width per word.
- `IDW`, $clog2(N) — width of the source-ID field; derived, do not override.

Ports:
- `clk`  in  1  — write-domain clock, the same clock as the FIFO `wclk`.
- `rst_n`  in  1  — synchronous, active-low reset.
- `req_valid`  in  N  — bit i is high when requester i presents a word.
- `req_data`  in  N*W  — requester i payload, in bits [i*W +: W].
- `req_last`  in  N  — bit i marks requester i's current word as the end of its burst.
- `req_ack`  out  N  — one-hot, single-cycle pulse: requester i's word was accepted this cycle.
- `fifo_wdata`  out  W+IDW+1  — word to the FIFO, packed as {last, id, payload}.
- `fifo_wput`  out  1  — write strobe to the FIFO.
- `fifo_wrdy`  in  1  — FIFO ready (not full).
- `locked`  out  1  — a burst is in progress.
- `owner`  out  IDW  — ID of the requester holding the lock.

## Operation
State:
- `out_valid` — the staged word is held in `fifo_wdata`.
- `rr_ptr` — round-robin priority pointer, IDW bits.
- `locked` and `owner` — burst lock state.

FIFO side:
- `fifo_wput` = `out_valid` & `fifo_wrdy`, combinational from registers and the input.
- The word stays stable while `out_valid` is high and `fifo_wput` is low.

Load:
- `load_en` = !`out_valid` | `fifo_wput`.
- This gives back-to-back operation: the FIFO consumes the staged word and a new one loads in the same cycle.

Selection, evaluated only when `load_en` is high:
- When `locked` = 1, only `owner` is eligible. Other requesters wait, even if the owner drops `req_valid`.
- When `locked` = 0, the first requester with `req_valid` set is granted, searching from `rr_ptr` upward and wrapping modulo N.
- When nothing is eligible, no load occurs and `out_valid` clears if `fifo_wput` is high.

On a load of requester g:
- `fifo_wdata` <= {`req_last`[g], g, payload_g}.
- `out_valid` <= 1.
- `req_ack`[g] pulses in the same cycle.
- If `req_last`[g] = 0: `locked` <= 1 and `owner` <= g.
- If `req_last`[g] = 1: `locked` <= 0 and `rr_ptr` <= (g+1) mod N.

Requester rules:
- A requester holds its valid, data and last stable until it sees ack.
- It may present its next word in the cycle after ack.
- A single-word transfer is a word with `last` = 1 and no lock.
- Burst length is unbounded. There is no timeout, and requesters must terminate their bursts.

## Timing
- Reset values: `req_ack` = 0, `fifo_wput` = 0, `fifo_wdata` = 0, `locked` = 0, `owner` = 0; internally `out_valid` = 0 and `rr_ptr` = 0.
- Request-to-ack latency: 0 cycles. Ack is combinational in the load cycle, and the data is registered at that edge.
- Request-to-FIFO latency: `fifo_wput` is asserted at the earliest 1 cycle after ack, and only when `fifo_wrdy` is high.
- Throughput: at most 1 word per cycle, bounded by how often `fifo_wrdy` returns. With the 1-deep FIFO this is about 1 word per round-trip synchronization.
- Reset mid-operation: the staged word is discarded without a put, the lock is released, and no ack is issued in the reset cycle.
- Simultaneous put and load: the handover is lossless and no word is duplicated.
- `rr_ptr` wraps from N-1 to 0.

## Test plan
- Single requester: req 2 presents 0x5A with last=1. Required response: ack[2] pulses in that cycle; with `fifo_wrdy`=1, `fifo_wput` follows 1 cycle later with `fifo_wdata`={1,2,0x5A}; `locked` stays 0.
- Round robin: all 4 requesters hold valid with last=1 and `fifo_wrdy` tied high. Required response: acks go 0,1,2,3,0 on consecutive cycles, and `fifo_wput` is high on every cycle after the first.
- Burst lock: req 1 sends 3 words (last=0,0,1) while req 0 and req 3 are also requesting. Required response: all 3 words carry id 1 and are contiguous; then req 3 is granted (search from `rr_ptr`=2) before req 0.
- Backpressure: hold `fifo_wrdy` low for 10 cycles with a word staged and req 0 pending. Required response: `fifo_wdata` stays stable, no ack is issued, and `fifo_wput` stays 0; when wrdy rises, put and ack[0] occur in the same cycle.
- Owner drop: req 2 is locked mid-burst, drops valid for 5 cycles while req 0 requests. Required response: req 0 is not acked; the burst resumes when req 2 re-asserts valid.
- Reset: assert `rst_n`=0 while locked with a word staged. Required response: the next cycle shows `locked`=0, no `fifo_wput`, and all outputs 0; after release, the first grant is the lowest valid requester from 0.
